// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// Holds the default operand widths and the state encoding used by
// seq_divider. No ports; import with "import seq_arith_pkg::*;".
package seq_arith_pkg;

  // Default widths: the divider inverts the 4x4 multiplier, so an 8-bit
  // product divided by a 4-bit factor.
  localparam int DEF_N_W = 8;
  localparam int DEF_D_W = 4;

  // Divider FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   p        in  D_W+1  partial remainder before the step (always < d_reg)
//   next_bit in  1      next dividend bit, shifted in at the LSB
//   d_reg    in  D_W    divisor
//   p_next   out D_W+1  partial remainder after the step
//   q_bit    out 1      quotient bit produced by this step
module div_step #(
  parameter int D_W = 4
) (
  input  logic [D_W:0]   p,
  input  logic           next_bit,
  input  logic [D_W-1:0] d_reg,
  output logic [D_W:0]   p_next,
  output logic           q_bit
);

  // The trial value is built from the whole of p rather than p[D_W-1:0].
  // Because p < d_reg, p[D_W] is always 0, so this is the same value, and
  // t - d_reg is always < d_reg, so it fits back into D_W+1 bits.
  logic [D_W+1:0] t;
  logic [D_W+1:0] diff;

  always_comb begin
    t      = {p, next_bit};
    diff   = t - {2'b00, d_reg};
    q_bit  = (t >= {2'b00, d_reg});
    p_next = q_bit ? diff[D_W:0] : t[D_W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Ports:
//   clk          in  1    rising-edge clock
//   rst          in  1    synchronous active-high reset
//   start        in  1    request a division (sampled only in IDLE)
//   dividend     in  N_W  numerator, sampled with start
//   divisor      in  D_W  denominator, sampled with start
//   busy         out 1    high in CALC and DONE
//   done         out 1    one-cycle pulse, results valid from this cycle
//   quotient     out N_W  registered quotient
//   remainder    out D_W  registered remainder
//   div_by_zero  out 1    set when the sampled divisor was 0
//
// Handshake: start is a request that is accepted only on an edge where
// busy=0; it is neither queued nor acknowledged otherwise. Results are
// valid from the done cycle and hold until the next accepted start.
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int N_W = DEF_N_W,
  parameter int D_W = DEF_D_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(N_W + 1);

  logic [1:0]       state;
  logic [N_W-1:0]   shreg;
  logic [D_W-1:0]   d_reg;
  logic [D_W:0]     p;
  logic [CNT_W-1:0] cnt;

  logic [D_W:0]     p_next;
  logic             q_bit;

  div_step #(.D_W(D_W)) u_step (
    .p        (p),
    .next_bit (shreg[N_W-1]),
    .d_reg    (d_reg),
    .p_next   (p_next),
    .q_bit    (q_bit)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      d_reg       <= '0;
      p           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg       <= dividend;
            d_reg       <= divisor;
            p           <= '0;
            cnt         <= CNT_W'(N_W);
            div_by_zero <= (divisor == '0);
            remainder   <= '0;
            if (divisor == '0) begin
              // Divide by zero skips CALC and reports an all-ones quotient.
              quotient <= '1;
              state    <= ST_DONE;
            end else begin
              // N_W shifts fully replace this, cleared only for tidiness.
              quotient <= '0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          p         <= p_next;
          quotient  <= {quotient[N_W-2:0], q_bit};
          remainder <= p_next[D_W-1:0];
          shreg     <= {shreg[N_W-2:0], 1'b0};
          cnt       <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_errors;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one start in the current (IDLE) cycle, then wait for done.
  // lat returns the cycle index of done, counting the start cycle as 0;
  // it stays at the bound (20) when done never appears.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if (quotient !== 8'd0 || remainder !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_results: q=%0d r=%0d expected 0/0", quotient, remainder);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bad_busy;
    int bad_done;
    bad_busy = 0;
    bad_done = 0;
    dividend = 8'd225;
    divisor  = 4'd15;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy !== (cyc <= 9)) bad_busy++;
      if (done !== (cyc == 9)) bad_done++;
      if (cyc == 9) begin
        n_checks++;
        if (quotient !== 8'd15 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
          n_errors++;
          $display("FAIL basic_225_15: q=%0d r=%0d dbz=%b expected 15/0/0",
                   quotient, remainder, div_by_zero);
        end
      end
      tick();
    end
    n_checks++;
    if (bad_busy !== 0) begin
      n_errors++;
      $display("FAIL basic_busy_window: %0d wrong cycles, expected 0", bad_busy);
    end
    n_checks++;
    if (bad_done !== 0) begin
      n_errors++;
      $display("FAIL basic_done_cycle: %0d wrong cycles, expected 0", bad_done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_div(8'd100, 4'd7, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd14 || remainder !== 4'd2) begin
      n_errors++;
      $display("FAIL b2b_100_7: lat=%0d q=%0d r=%0d expected 9/14/2", lat, quotient, remainder);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle_after_done: busy=%b expected 0", busy);
    end
    run_div(8'd3, 4'd15, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd0 || remainder !== 4'd3) begin
      n_errors++;
      $display("FAIL b2b_3_15: lat=%0d q=%0d r=%0d expected 9/0/3", lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int lat;
    run_div(8'd5, 4'd0, lat);
    n_checks++;
    if (lat !== 1 || quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      n_errors++;
      $display("FAIL div_zero_5_0: lat=%0d q=%0h r=%0d dbz=%b expected 1/ff/0/1",
               lat, quotient, remainder, div_by_zero);
    end
    tick();
    n_checks++;
    if (div_by_zero !== 1'b1 || quotient !== 8'hFF) begin
      n_errors++;
      $display("FAIL div_zero_hold: q=%0h dbz=%b expected ff/1", quotient, div_by_zero);
    end
    run_div(8'd70, 4'd10, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd7 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_errors++;
      $display("FAIL div_zero_then_70_10: lat=%0d q=%0d r=%0d dbz=%b expected 9/7/0/0",
               lat, quotient, remainder, div_by_zero);
    end
    tick();
  endtask

  task automatic test_start_held();
    int n_done;
    int bad_pos;
    int bad_res;
    n_done  = 0;
    bad_pos = 0;
    bad_res = 0;
    dividend = 8'd255;
    divisor  = 4'd1;
    start    = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 32; cyc++) begin
      // Changed mid-CALC: the running 255/1 must ignore it; later restarts see 200/7.
      if (cyc == 4) begin
        dividend = 8'd200;
        divisor  = 4'd7;
      end
      if (done) begin
        n_done++;
        if (cyc != 9 && cyc != 19 && cyc != 29) bad_pos++;
        if (cyc == 9 && (quotient !== 8'd255 || remainder !== 4'd0)) bad_res++;
        if (cyc != 9 && (quotient !== 8'd28 || remainder !== 4'd4)) bad_res++;
      end
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (n_done !== 3) begin
      n_errors++;
      $display("FAIL held_done_count: got %0d done pulses, expected 3", n_done);
    end
    n_checks++;
    if (bad_pos !== 0) begin
      n_errors++;
      $display("FAIL held_done_spacing: %0d misplaced pulses, expected 0", bad_pos);
    end
    n_checks++;
    if (bad_res !== 0) begin
      n_errors++;
      $display("FAIL held_results: %0d wrong results (255/1 then 200/7), expected 0", bad_res);
    end
    for (int i = 0; i < 12 && busy; i++) tick();
  endtask

  task automatic test_reset_abort();
    int n_done;
    int lat;
    n_done   = 0;
    dividend = 8'd200;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 4'd0) begin
      n_errors++;
      $display("FAIL abort_outputs: busy/done/dbz=%b q=%0d r=%0d expected 000/0/0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    for (int i = 0; i < 15; i++) begin
      if (done) n_done++;
      tick();
    end
    n_checks++;
    if (n_done !== 0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", n_done);
    end
    run_div(8'd200, 4'd3, lat);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd66 || remainder !== 4'd2) begin
      n_errors++;
      $display("FAIL abort_rerun_200_3: lat=%0d q=%0d r=%0d expected 9/66/2", lat, quotient, remainder);
    end
    tick();
  endtask

  task automatic test_multiplier_inverse();
    int lat;
    // 7 * 15 = 0x69 from the 4x4 multiplier.
    run_div(8'h69, 4'hF, lat);
    n_checks++;
    if (quotient !== 8'd7 || remainder !== 4'd0) begin
      n_errors++;
      $display("FAIL mult_inverse_69_f: q=%0d r=%0d expected 7/0", quotient, remainder);
    end
    tick();
    // Full-width quotient.
    run_div(8'd255, 4'd1, lat);
    n_checks++;
    if (quotient !== 8'd255 || remainder !== 4'd0) begin
      n_errors++;
      $display("FAIL full_width_255_1: q=%0d r=%0d expected 255/0", quotient, remainder);
    end
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    int exp_q;
    int exp_r;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        exp_q = a / b;
        exp_r = a % b;
        run_div(8'(a), 4'(b), lat);
        n_checks++;
        if (lat !== 9 || int'(quotient) * b + int'(remainder) !== a || int'(remainder) >= b
            || int'(quotient) !== exp_q || int'(remainder) !== exp_r) begin
          n_errors++;
          $display("FAIL sweep_%0d_%0d: lat=%0d q=%0d r=%0d expected 9/%0d/%0d",
                   a, b, lat, quotient, remainder, exp_q, exp_r);
        end
        tick();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_held();
    test_reset_abort();
    test_multiplier_inverse();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
